// File: rtl/mod_reduce.sv
// Signed 2W-bit product reduced to its canonical residue mod p by restoring shift-subtract.
// Latency: 2W+2 cycles from capture to ready (2 cycles when p < 2 or product == 0).
// No backpressure: enable is sampled only when idle; requests arriving while busy are dropped.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module mod_reduce (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [2*`DATAWIDTH-1:0]   product,
  input  logic [`DATAWIDTH-1:0]     modulus,
  output logic [`DATAWIDTH-1:0]     residue,
  output logic                      ready,
  output logic                      busy
);

  localparam int W  = `DATAWIDTH;
  localparam int KW = $clog2(2 * W);
  localparam logic [KW-1:0] K_MAX = KW'(2 * W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_FIX    = 2'd2
  } state_t;

  state_t          state_q;
  logic [2*W-1:0]  mag_q;
  logic            neg_q;
  logic [W-1:0]    p_q;
  // The remainder is always < p after a step, so W bits hold it; the extra
  // bit of the shifted value only exists transiently in t_d.
  logic [W-1:0]    r_q;
  logic [KW-1:0]   k_q;
  logic            skip_q;
  logic [W-1:0]    residue_q;
  logic            ready_q;
  logic            busy_q;

  logic [2*W-1:0]  mag_d;
  logic            fast_d;
  logic [W:0]      t_d;
  logic [W-1:0]    r_d;
  logic [W-1:0]    res_d;

  // Capture-side magnitude/fast-path decode, one restoring step, and the sign fix-up.
  always_comb begin
    mag_d  = product[2*W-1] ? (~product + 1'b1) : product;
    fast_d = (modulus < W'(2)) || (product == '0);
    t_d    = {r_q, mag_q[k_q]};
    // t < 2p, so t - p fits in W bits whenever it is taken.
    r_d    = (t_d >= {1'b0, p_q}) ? (t_d[W-1:0] - p_q) : t_d[W-1:0];
    if (skip_q) begin
      res_d = '0;
    end else if (neg_q && (r_q != '0)) begin
      res_d = p_q - r_q;
    end else begin
      res_d = r_q;
    end
  end

  // Control FSM with registered outputs; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      p_q       <= '0;
      r_q       <= '0;
      k_q       <= '0;
      skip_q    <= 1'b0;
      residue_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            mag_q   <= mag_d;
            neg_q   <= product[2*W-1];
            p_q     <= modulus;
            r_q     <= '0;
            k_q     <= K_MAX;
            skip_q  <= fast_d;
            busy_q  <= 1'b1;
            state_q <= fast_d ? S_FIX : S_REDUCE;
          end
        end
        S_REDUCE: begin
          r_q <= r_d;
          if (k_q == '0) begin
            state_q <= S_FIX;
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        S_FIX: begin
          residue_q <= res_d;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign residue = residue_q;
  assign ready   = ready_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mod_reduce.sv
// Self-checking bench for mod_reduce: cycle-level reference model plus directed literal cases.
// Model tracks only "cycles remaining" and the arithmetic residue of the captured product.
// Random enable traffic exercises requests dropped while busy and back-to-back captures.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module tb_mod_reduce;

  localparam int W = `DATAWIDTH;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [2*W-1:0] product;
  logic [W-1:0]   modulus;
  logic [W-1:0]   residue;
  logic           ready;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;

  mod_reduce dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .product (product),
    .modulus (modulus),
    .residue (residue),
    .ready   (ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Mathematical residue of a signed product, canonical in [0, m-1].
  function automatic logic [W-1:0] ref_mod(input logic [2*W-1:0] prod, input logic [W-1:0] m);
    longint v;
    longint mm;
    longint r;
    logic [63:0] ru;
    v  = longint'($signed(prod));
    mm = longint'(m);
    if (mm < 2 || v == 0) return '0;
    r = v % mm;
    if (r < 0) r = r + mm;
    ru = 64'(r);
    return ru[W-1:0];
  endfunction

  // Reference model: an operation takes a fixed number of edges, then the result appears.
  int           m_cnt = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_res = '0;
  bit           m_rdy = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_res = '0;
      m_rdy = 0;
    end else begin
      m_rdy = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_res = m_pend;
          m_rdy = 1;
        end
      end else if (enable) begin
        m_pend = ref_mod(product, modulus);
        m_cnt  = ((modulus < 2) || (product == '0)) ? 1 : 2 * W + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready",   32'(ready),   32'(m_rdy));
      chk("busy",    32'(busy),    32'(m_cnt > 0));
      chk("residue", 32'(residue), 32'(m_res));
    end
  end

  // Issue one request, wait for ready, check residue and the edge on which it landed.
  task automatic run_op(input string nm, input logic [2*W-1:0] prod, input logic [W-1:0] m,
                        input int exp_res, input int exp_edge);
    int cyc;
    enable  = 1'b1;
    product = prod;
    modulus = m;
    @(negedge clk);
    cyc = 1;
    enable  = 1'b0;
    product = (2*W)'($urandom);
    modulus = W'($urandom);
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_edge"},    32'(cyc - 1),  32'(exp_edge));
    chk({nm, "_residue"}, 32'(residue),  32'(exp_res));
  endtask

  localparam int EDGE_N = 2 * W + 1;

  initial begin
    int t1;
    int t2;
    int cyc;
    rst_n   = 1'b0;
    enable  = 1'b0;
    product = '0;
    modulus = '0;
    repeat (2) @(negedge clk);
    chk("rst_residue", 32'(residue), 32'd0);
    chk("rst_ready",   32'(ready),   32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    rst_n = 1'b1;
    chk_on = 1;
    @(negedge clk);

    // Directed literal cases.
    run_op("pos1000",   (2*W)'(1000),   8'd251, 247, EDGE_N);
    run_op("neg1000",   (2*W)'(-1000),  8'd251, 4,   EDGE_N);
    run_op("negmult",   (2*W)'(-25100), 8'd251, 0,   EDGE_N);
    run_op("mostneg",   (2*W)'(-32768), 8'd251, 113, EDGE_N);
    run_op("mostpos",   (2*W)'(32767),  8'd251, 137, EDGE_N);
    run_op("zero",      (2*W)'(0),      8'd251, 0,   1);
    run_op("mod0",      (2*W)'(1234),   8'd0,   0,   1);
    run_op("mod1",      (2*W)'(1234),   8'd1,   0,   1);
    run_op("pos1000b",  (2*W)'(1000),   8'd251, 247, EDGE_N);

    // Back-to-back with enable held high; the product change during busy must be ignored.
    enable  = 1'b1;
    product = (2*W)'(1000);
    modulus = 8'd251;
    @(negedge clk);
    cyc = 1;
    product = (2*W)'(-1000);
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    t1 = cyc;
    chk("b2b_first", 32'(residue), 32'd247);
    @(negedge clk);
    cyc++;
    product = (2*W)'(5);
    modulus = 8'd7;
    while (!ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    t2 = cyc;
    enable = 1'b0;
    chk("b2b_second", 32'(residue), 32'd4);
    chk("b2b_gap",    32'(t2 - t1), 32'(2 * W + 2));
    @(negedge clk);

    // Reset in the middle of a reduction.
    enable  = 1'b1;
    product = (2*W)'(1000);
    modulus = 8'd251;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_residue", 32'(residue), 32'd0);
    chk("midrst_ready",   32'(ready),   32'd0);
    chk("midrst_busy",    32'(busy),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * W) @(negedge clk);
    run_op("post_rst", (2*W)'(1000), 8'd251, 247, EDGE_N);

    // Randomized traffic with edge-case biasing; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: product = '0;
        1: product = {1'b1, {(2*W-1){1'b0}}};
        2: product = {1'b0, {(2*W-1){1'b1}}};
        default: product = (2*W)'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0: modulus = W'($urandom_range(0, 2));
        1: modulus = {W{1'b1}};
        default: modulus = W'($urandom);
      endcase
      @(negedge clk);
    end
    enable = 1'b0;
    repeat (2 * W + 4) @(negedge clk);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
